// File: rtl/branch_resolve_predict_if.sv
// branch_resolve_predict_if: pipeline <-> branch unit bundle for IF lookup and EX resolve/train
//   master (pipeline) drives if_pc, ex_valid, ex_branch, ex_func3, ex_rs1, ex_rs2, ex_pc, ex_pred_taken
//   slave (branch unit) drives if_pred_taken, ex_taken, ex_mispredict, ex_illegal, br_count, mp_count
interface branch_resolve_predict_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  if_pc;
    logic             if_pred_taken;
    logic             ex_valid;
    logic             ex_branch;
    logic [2:0]       ex_func3;
    logic [XLEN-1:0]  ex_rs1;
    logic [XLEN-1:0]  ex_rs2;
    logic [XLEN-1:0]  ex_pc;
    logic             ex_pred_taken;
    logic             ex_taken;
    logic             ex_mispredict;
    logic             ex_illegal;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mp_count;

    modport master (
        output if_pc, ex_valid, ex_branch, ex_func3, ex_rs1, ex_rs2, ex_pc, ex_pred_taken,
        input  if_pred_taken, ex_taken, ex_mispredict, ex_illegal, br_count, mp_count
    );

    modport slave (
        input  if_pc, ex_valid, ex_branch, ex_func3, ex_rs1, ex_rs2, ex_pc, ex_pred_taken,
        output if_pred_taken, ex_taken, ex_mispredict, ex_illegal, br_count, mp_count
    );
endinterface

// File: rtl/branch_resolve_predict.sv
// branch_resolve_predict: RV32I branch resolve in EX plus direct-mapped 2-bit BHT predictor for IF
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (BHT -> weak-NT, statistics -> 0)
//   bus  slave side of branch_resolve_predict_if (IF lookup, EX resolve/train, statistics)
module branch_resolve_predict #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int IDX_LSB     = 2,
    parameter int CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    branch_resolve_predict_if.slave bus
);
    localparam int IW = $clog2(BHT_ENTRIES);

    logic [1:0]    bht [BHT_ENTRIES];
    logic [IW-1:0] if_idx, ex_idx;
    logic          reserved, eq, lt, ltu, cond, resolve, train;
    logic [1:0]    cur;

    // only the index slice of each PC is consumed; the sink keeps the rest lint-visible
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.if_pc, bus.ex_pc};

    assign if_idx = bus.if_pc[IDX_LSB +: IW];
    assign ex_idx = bus.ex_pc[IDX_LSB +: IW];

    // func3[2] selects relational vs equality, func3[1] unsigned, func3[0] inverts the sense
    assign reserved = bus.ex_func3[2:1] == 2'b01;
    assign eq       = bus.ex_rs1 == bus.ex_rs2;
    assign lt       = $signed(bus.ex_rs1) < $signed(bus.ex_rs2);
    assign ltu      = bus.ex_rs1 < bus.ex_rs2;
    assign cond     = (bus.ex_func3[2] ? (bus.ex_func3[1] ? ltu : lt) : eq) ^ bus.ex_func3[0];

    assign resolve           = bus.ex_valid & bus.ex_branch;
    assign train             = resolve & ~reserved;
    assign bus.ex_taken      = train & cond;
    assign bus.ex_illegal    = resolve & reserved;
    assign bus.ex_mispredict = train & (bus.ex_taken != bus.ex_pred_taken);

    // lookup sees pre-edge contents; a same-cycle update is deliberately not bypassed
    assign bus.if_pred_taken = bht[if_idx][1];
    assign cur               = bht[ex_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
            bus.br_count <= '0;
            bus.mp_count <= '0;
        end else if (train) begin
            bht[ex_idx]  <= bus.ex_taken ? (cur == 2'b11 ? cur : cur + 2'b01)
                                         : (cur == 2'b00 ? cur : cur - 2'b01);
            bus.br_count <= bus.br_count + 1'b1;
            bus.mp_count <= bus.mp_count + {{(CNT_W-1){1'b0}}, bus.ex_mispredict};
        end
    end
endmodule

// File: tb/tb_branch_resolve_predict.sv
// tb_branch_resolve_predict: directed scoreboard bench for branch_resolve_predict
module tb_branch_resolve_predict;
    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_resolve_predict_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    branch_resolve_predict #(
        .XLEN(XLEN), .BHT_ENTRIES(16), .IDX_LSB(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          nchk  = 0;
    int          nfail = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic pop(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        nchk++;
        if (exp_q.size() == 0) begin
            nfail++;
            $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                nfail++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    task automatic drive(input string t, input logic v, input logic b, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] c, input logic [31:0] pc,
                         input logic pr, input logic et, input logic ei, input logic em);
        @(negedge clk);
        bus.ex_valid      = v;
        bus.ex_branch     = b;
        bus.ex_func3      = f3;
        bus.ex_rs1        = a;
        bus.ex_rs2        = c;
        bus.ex_pc         = pc;
        bus.ex_pred_taken = pr;
        push({t, "_taken"}, {31'd0, et});
        push({t, "_illegal"}, {31'd0, ei});
        push({t, "_mispredict"}, {31'd0, em});
        #1;
        pop({31'd0, bus.ex_taken});
        pop({31'd0, bus.ex_illegal});
        pop({31'd0, bus.ex_mispredict});
    endtask

    task automatic state(input string t, input logic [31:0] pc, input logic ep,
                         input logic [31:0] ebr, input logic [31:0] emp);
        @(negedge clk);
        bus.ex_valid = 1'b0;
        bus.if_pc    = pc;
        push({t, "_pred"}, {31'd0, ep});
        push({t, "_br_count"}, ebr);
        push({t, "_mp_count"}, emp);
        #1;
        pop({31'd0, bus.if_pred_taken});
        pop(bus.br_count);
        pop(bus.mp_count);
    endtask

    initial begin
        bus.if_pc = 32'h40;
        bus.ex_valid = 1'b0;
        bus.ex_branch = 1'b0;
        bus.ex_func3 = 3'b000;
        bus.ex_rs1 = '0;
        bus.ex_rs2 = '0;
        bus.ex_pc = '0;
        bus.ex_pred_taken = 1'b0;
        #12;
        rst = 1'b0;
        state("reset", 32'h40, 1'b0, 0, 0);

        drive("beq_eq", 1, 1, 3'b000, 5, 5, 32'h40, 0, 1, 0, 1);
        push("beq_pre_edge_pred", 0);
        pop({31'd0, bus.if_pred_taken});
        state("beq_after", 32'h40, 1'b1, 1, 1);

        drive("blt_ovf", 1, 1, 3'b100, 32'h8000_0000, 1, 32'h4C, 1, 1, 0, 0);
        drive("bltu", 1, 1, 3'b110, 32'h8000_0000, 1, 32'h4C, 1, 0, 0, 1);
        drive("bgeu", 1, 1, 3'b111, 32'h8000_0000, 1, 32'h4C, 0, 1, 0, 1);
        drive("bge_ovf", 1, 1, 3'b101, 32'h8000_0000, 1, 32'h4C, 0, 0, 0, 0);
        state("cmp_after", 32'h4C, 1'b0, 5, 3);

        for (int i = 0; i < 5; i++) drive("bne_t", 1, 1, 3'b001, 1, 2, 32'h44, 1, 1, 0, 0);
        state("sat_hi", 32'h44, 1'b1, 10, 3);
        drive("bne_nt1", 1, 1, 3'b001, 3, 3, 32'h44, 1, 0, 0, 1);
        state("sat_10", 32'h44, 1'b1, 11, 4);
        drive("bne_nt2", 1, 1, 3'b001, 3, 3, 32'h44, 1, 0, 0, 1);
        drive("bne_nt3", 1, 1, 3'b001, 3, 3, 32'h44, 1, 0, 0, 1);
        state("sat_01", 32'h44, 1'b0, 13, 6);

        drive("rsv010", 1, 1, 3'b010, 1, 2, 32'h40, 1, 0, 1, 0);
        drive("rsv011", 1, 1, 3'b011, 3, 3, 32'h40, 1, 0, 1, 0);
        state("rsv_after", 32'h40, 1'b1, 13, 6);
        drive("no_valid", 0, 1, 3'b000, 1, 2, 32'h40, 1, 0, 0, 0);
        drive("no_branch", 1, 0, 3'b000, 1, 2, 32'h40, 1, 0, 0, 0);
        state("idle_after", 32'h40, 1'b1, 13, 6);

        bus.if_pc = 32'h48;
        drive("hazard", 1, 1, 3'b000, 7, 7, 32'h48, 0, 1, 0, 1);
        push("hazard_same_cycle_pred", 0);
        pop({31'd0, bus.if_pred_taken});
        state("hazard_next", 32'h48, 1'b1, 14, 7);

        drive("pre_rst", 1, 1, 3'b000, 7, 7, 32'h48, 0, 1, 0, 1);
        #2;
        rst = 1'b1;
        push("rst_pred", 0);
        push("rst_br_count", 0);
        push("rst_mp_count", 0);
        push("rst_comb_taken", 1);
        #1;
        pop({31'd0, bus.if_pred_taken});
        pop(bus.br_count);
        pop(bus.mp_count);
        pop({31'd0, bus.ex_taken});
        @(negedge clk);
        rst = 1'b0;
        state("post_rst_train", 32'h48, 1'b1, 1, 1);
        state("post_rst_other", 32'h40, 1'b0, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
